// File: rtl/spi_sample_rx_if.sv
// Signal bundle between the SPI sample receiver and its neighbours: the SPI
// master lines, the frame handshake and the buffer read port.
interface spi_sample_rx_if #(
    parameter int ADDR_W = 6
);
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_cs_n;
    logic [ADDR_W:0]   frame_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              frame_valid;
    logic              frame_ack;
    logic              byte_err;
    logic              overflow;
    logic              state_dbg;

    // Handshake: frame_valid rises on the edge that writes the last sample and
    // stays high until frame_ack is sampled high; that edge drops frame_valid
    // and rewinds the write pointer. frame_ack while frame_valid is low is ignored.
    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n, frame_len, rd_addr, frame_ack,
        output rd_data, rx_byte, rx_valid, frame_valid, byte_err, overflow, state_dbg
    );

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n, frame_len, rd_addr, frame_ack,
        input  rd_data, rx_byte, rx_valid, frame_valid, byte_err, overflow, state_dbg
    );
endinterface

// File: rtl/spi_sample_rx.sv
// SPI mode-0 slave receiver: oversamples the SPI lines, assembles MSB-first
// bytes and collects frame_len of them into a buffer for the FFT input stage.
module spi_sample_rx #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input logic           clk,
    input logic           rst,
    spi_sample_rx_if.slave bus
);
    typedef enum logic {RECV = 1'b0, FULL = 1'b1} state_t;

    state_t state_q, state_d;

    logic sclk_s1, sclk_s2, sclk_prev;
    logic mosi_s1, mosi_s2;
    logic cs_s1, cs_s2, cs_prev;

    logic [6:0]        shift_q;
    logic [7:0]        shift_nx;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        rx_byte_q;
    logic              rx_valid_q;
    logic              byte_err_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   eff_len;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem [DEPTH];

    logic sclk_rise, cs_rise, byte_done, last_idx;
    logic wr_en, ptr_clr, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_s1   <= bus.spi_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            mosi_s1   <= bus.spi_mosi;
            mosi_s2   <= mosi_s1;
            cs_s1     <= bus.spi_cs_n;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_prev & ~cs_s2;
    assign cs_rise   = cs_s2 & ~cs_prev;
    assign shift_nx  = {shift_q, mosi_s2};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // Only seven bits need holding: the eighth arrives with the completing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (sclk_rise) begin
            shift_q   <= shift_nx[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end else if (cs_rise && (bit_cnt_q != 3'd0)) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            byte_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (byte_done) rx_byte_q <= shift_nx;
            rx_valid_q <= byte_done;
            byte_err_q <= cs_rise && (bit_cnt_q != 3'd0);
            overflow_q <= ovf_d;
        end
    end

    // A zero length means a full DEPTH frame, i.e. the last index is all ones.
    assign eff_len  = (wr_ptr_q == '0) ? bus.frame_len : len_q;
    assign last_idx = (eff_len == '0) ? (wr_ptr_q == '1)
                                      : ({1'b0, wr_ptr_q} == eff_len - (ADDR_W+1)'(1));

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        ptr_clr = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            RECV: begin
                if (byte_done) begin
                    wr_en = 1'b1;
                    if (last_idx) state_d = FULL;
                end
            end
            FULL: begin
                if (byte_done) ovf_d = 1'b1;
                if (bus.frame_ack) begin
                    state_d = RECV;
                    ptr_clr = 1'b1;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RECV;
            wr_ptr_q <= '0;
            len_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ptr_clr)    wr_ptr_q <= '0;
            else if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_en && (wr_ptr_q == '0)) len_q <= bus.frame_len;
        end
    end

    // Buffer kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr_q] <= shift_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= mem[bus.rd_addr];
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_valid = (state_q == FULL);
    assign bus.byte_err    = byte_err_q;
    assign bus.overflow    = overflow_q;
    assign bus.state_dbg   = logic'(state_q);
endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: drives SPI mode-0 at clk/4 and checks the
// byte stream, frame handshake, error pulses and buffer contents.
module tb_spi_sample_rx;
  localparam int ADDR_W = 6;
  localparam logic ST_RECV = 1'b0;
  localparam logic ST_FULL = 1'b1;

  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int ovf_cnt = 0;
  int err_cnt = 0;
  logic last_fv_at_rx = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  spi_sample_rx_if #(.ADDR_W(ADDR_W)) bus ();

  spi_sample_rx #(.DEPTH(64), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic spi_begin();
    bus.spi_cs_n = 1'b0;
    tick(2);
  endtask

  task automatic spi_end();
    tick(2);
    bus.spi_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic spi_bits(input logic [7:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = val[7-i];
      tick(2);
      bus.spi_sclk = 1'b1;
      tick(2);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    exp_q.push_back(b);
    spi_begin();
    spi_bits(b, 8);
    spi_end();
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] e);
    bus.rd_addr = a;
    tick(1);
    check(tag, bus.rd_data, e);
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    tick(1);
    bus.frame_ack = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  // scoreboard: every rx_valid cycle consumes one expected byte
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_cnt++;
      last_fv_at_rx = bus.frame_valid;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL rx_unexpected: observed %0h expected none", bus.rx_byte);
      end else begin
        exp_b = exp_q.pop_front();
        check("rx_byte_stream", bus.rx_byte, exp_b);
      end
    end
    if (bus.overflow) ovf_cnt++;
    if (bus.byte_err) err_cnt++;
  end

  initial begin
    rst = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.frame_len = 7'd4;
    bus.rd_addr = '0;
    bus.frame_ack = 1'b0;
    tick(3);

    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_rx_byte", bus.rx_byte, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_frame_valid", bus.frame_valid, 1'b0);
    check("rst_byte_err", bus.byte_err, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_state", bus.state_dbg, ST_RECV);
    rst = 1'b0;
    tick(2);

    // single byte, short frame not yet complete
    spi_byte(8'hA5);
    check("a5_rx_cnt", rx_cnt, 1);
    check("a5_rx_byte", bus.rx_byte, 8'hA5);
    check("a5_frame_valid", bus.frame_valid, 1'b0);
    read_check("a5_buf0", 6'd0, 8'hA5);

    // full 64-sample frame with frame_len = 0
    do_reset();
    bus.frame_len = 7'd0;
    for (int i = 0; i < 64; i++) begin
      spi_byte(8'(2 + 3 * i));
      if (i == 62) check("f64_fv_before_last", bus.frame_valid, 1'b0);
    end
    check("f64_fv_at_last_write", last_fv_at_rx, 1'b1);
    check("f64_frame_valid", bus.frame_valid, 1'b1);
    check("f64_state", bus.state_dbg, ST_FULL);
    for (int i = 0; i < 64; i++) read_check("f64_buf", 6'(i), 8'(2 + 3 * i));

    // release, 4-sample frame, then overflow while full
    pulse_ack();
    check("ack_frame_valid", bus.frame_valid, 1'b0);
    check("ack_state", bus.state_dbg, ST_RECV);
    bus.frame_len = 7'd4;
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_byte(8'h33);
    check("f4_fv_before_last", bus.frame_valid, 1'b0);
    spi_byte(8'h44);
    check("f4_frame_valid", bus.frame_valid, 1'b1);
    spi_byte(8'h55);
    spi_byte(8'h66);
    check("ovf_cnt", ovf_cnt, 2);
    check("ovf_frame_valid", bus.frame_valid, 1'b1);
    read_check("ovf_buf0", 6'd0, 8'h11);
    read_check("ovf_buf1", 6'd1, 8'h22);
    read_check("ovf_buf2", 6'd2, 8'h33);
    read_check("ovf_buf3", 6'd3, 8'h44);
    read_check("ovf_buf4", 6'd4, 8'h0E);
    pulse_ack();
    spi_byte(8'h3C);
    read_check("after_ack_buf0", 6'd0, 8'h3C);
    read_check("after_ack_buf1", 6'd1, 8'h22);

    // ack while receiving must not rewind the pointer
    pulse_ack();
    check("recv_ack_state", bus.state_dbg, ST_RECV);
    spi_byte(8'h77);
    read_check("recv_ack_buf1", 6'd1, 8'h77);
    read_check("recv_ack_buf0", 6'd0, 8'h3C);

    // partial byte aborted by chip select
    rx_cnt = 0;
    spi_begin();
    spi_bits(8'hF8, 5);
    spi_end();
    check("err_cnt", err_cnt, 1);
    check("err_no_rx", rx_cnt, 0);
    spi_byte(8'h81);
    check("err_then_rx_byte", bus.rx_byte, 8'h81);
    read_check("err_then_buf2", 6'd2, 8'h81);
    check("err_cnt_stable", err_cnt, 1);

    // two bytes back to back under one chip select
    do_reset();
    bus.frame_len = 7'd4;
    rx_cnt = 0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    spi_begin();
    spi_bits(8'h12, 8);
    spi_bits(8'h34, 8);
    spi_end();
    check("cont_rx_cnt", rx_cnt, 2);
    check("cont_frame_valid", bus.frame_valid, 1'b0);
    read_check("cont_buf0", 6'd0, 8'h12);
    read_check("cont_buf1", 6'd1, 8'h34);

    // reset mid-frame and mid-byte, then a fresh frame from address 0
    spi_byte(8'h56);
    rx_cnt = 0;
    spi_begin();
    spi_bits(8'hE0, 3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    spi_end();
    check("rst_mid_no_err", err_cnt, 1);
    check("rst_mid_no_rx", rx_cnt, 0);
    check("rst_mid_no_ovf", ovf_cnt, 2);
    check("rst_mid_frame_valid", bus.frame_valid, 1'b0);
    spi_byte(8'hA1);
    spi_byte(8'hB2);
    spi_byte(8'hC3);
    check("post_rst_fv_before_last", bus.frame_valid, 1'b0);
    spi_byte(8'hD4);
    check("post_rst_frame_valid", bus.frame_valid, 1'b1);
    read_check("post_rst_buf0", 6'd0, 8'hA1);
    read_check("post_rst_buf1", 6'd1, 8'hB2);
    read_check("post_rst_buf2", 6'd2, 8'hC3);
    read_check("post_rst_buf3", 6'd3, 8'hD4);
    check("exp_q_drained", exp_q.size(), 0);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
